seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the watch's multi-digit common-anode 7-segment display. Holds a frame-coherent snapshot of NUM_DIGITS hex nibbles, steps through the digits one at a time, decodes each nibble to active-low segments, and drives one anode per slot with a programmable dead-time between slots to suppress ghosting. Sits between the timekeeping/mode logic, which supplies the digits, and the display pins.

---
 rtl/seg_pkg.sv | 11 +
 rtl/seg_hex_decode.sv | 9 +
 rtl/seg_scan_ctrl.sv | 114 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared segment table, off pattern and scan FSM states for the display scanner.
package seg_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} seg_state_t;
  localparam logic [0:6] SEG_OFF = 7'b1111111;
  localparam logic [0:6] SEG_TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low segments a..g.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [0:6] o_seg
);
  assign o_seg = SEG_TBL[i_nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller with frame-coherent digit buffers.
// Define SEG_LZ_SUPPRESS_EN to blank leading zero digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic [0:6]              seg_n,
  output logic                    dp_n,
  output logic [IW-1:0]           scan_idx,
  output logic                    frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BL = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  seg_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [4*NUM_DIGITS-1:0] r_pdig, r_adig;
  logic [NUM_DIGITS-1:0] r_pdp, r_pblk, r_adp, r_ablk, r_anode;
  logic [0:6] r_seg;
  logic r_dp, r_fd;

  seg_state_t w_state_n;
  logic [CW-1:0] w_cnt_n;
  logic [IW-1:0] w_idx_n;
  logic [4*NUM_DIGITS-1:0] w_nxt_dig;
  logic [NUM_DIGITS-1:0] w_nxt_dp, w_nxt_blk, w_lz;
  logic [3:0] w_nib;
  logic [0:6] w_dec;
  logic w_wrap, w_bound, w_off;

  // Outputs are registered from next-state values so seg_n leads the anode by the dead-time.
  always_comb begin
    w_wrap = r_cnt == LAST;
    w_bound = enable && (r_state == IDLE || (w_wrap && r_idx == IDX_LAST));
    w_cnt_n = (!enable || r_state == IDLE || w_wrap) ? '0 : r_cnt + 1'b1;
    w_idx_n = (!enable || r_state == IDLE) ? '0 : !w_wrap ? r_idx : r_idx == IDX_LAST ? '0 : r_idx + 1'b1;
    w_state_n = !enable ? IDLE : w_cnt_n < BL ? BLANK : SHOW;
    w_nxt_dig = !w_bound ? r_adig : load ? digits_in : r_pdig;
    w_nxt_dp = !w_bound ? r_adp : load ? dp_in : r_pdp;
    w_nxt_blk = !w_bound ? r_ablk : load ? blank_in : r_pblk;
    w_nib = w_nxt_dig[{w_idx_n, 2'b00} +: 4];
    w_off = w_nxt_blk[w_idx_n] || w_lz[w_idx_n];
  end

`ifdef SEG_LZ_SUPPRESS_EN
  logic w_lz_run;
  always_comb begin
    w_lz = '0;
    w_lz_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_lz_run = w_lz_run && w_nxt_dig[4*k +: 4] == 4'h0;
      w_lz[k] = w_lz_run;
    end
  end
`else
  assign w_lz = '0;
`endif

  seg_hex_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_pdig <= '0;
      r_pdp <= '0;
      r_pblk <= '0;
      r_adig <= '0;
      r_adp <= '0;
      r_ablk <= '0;
      r_anode <= '1;
      r_seg <= SEG_OFF;
      r_dp <= 1'b1;
      r_fd <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt <= w_cnt_n;
      r_idx <= w_idx_n;
      if (load) {r_pdig, r_pdp, r_pblk} <= {digits_in, dp_in, blank_in};
      r_adig <= w_nxt_dig;
      r_adp <= w_nxt_dp;
      r_ablk <= w_nxt_blk;
      r_anode <= w_state_n == SHOW ? ~(NUM_DIGITS'(1) << w_idx_n) : '1;
      r_seg <= (w_state_n == IDLE || w_off) ? SEG_OFF : w_dec;
      r_dp <= w_state_n == IDLE || w_nxt_blk[w_idx_n] || !w_nxt_dp[w_idx_n];
      r_fd <= w_state_n != IDLE && w_cnt_n == LAST && w_idx_n == IDX_LAST;
    end
  end

  assign anode_n = r_anode;
  assign seg_n = r_seg;
  assign dp_n = r_dp;
  assign scan_idx = r_idx;
  assign frame_done = r_fd;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table-driven frame checks plus boundary, enable and async-reset sequences.
module tb_seg_scan_ctrl;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] dp_in = '0, blank_in = '0;
  logic [3:0] anode_n;
  logic [0:6] seg_n;
  logic dp_n, frame_done;
  logic [1:0] scan_idx;
  int total = 0, bad = 0;
  int idx;
  logic [3:0] ea;

  typedef struct {
    logic [15:0] dig;
    logic [3:0] dp;
    logic [3:0] blk;
    logic [3:0][0:6] seg;
    logic [3:0] dpn;
  } vec_t;
  localparam int NV = 5;
  vec_t vt [NV];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .anode_n    (anode_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .scan_idx   (scan_idx),
    .frame_done (frame_done)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_dark(input string nm);
    chk({nm, "_anode"}, 8'(anode_n), 8'hF);
    chk({nm, "_seg"}, 8'(seg_n), 8'h7F);
    chk({nm, "_dp"}, 8'(dp_n), 8'h1);
    chk({nm, "_idx"}, 8'(scan_idx), 8'h0);
    chk({nm, "_fdone"}, 8'(frame_done), 8'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // seg fields list digits 3..0
    vt[0] = '{16'h1234, 4'h0, 4'h0, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF};
    vt[1] = '{16'hABCD, 4'h0, 4'h0, {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}, 4'hF};
    vt[2] = '{16'h5678, 4'b0100, 4'b0100, {7'b0100100, 7'b1111111, 7'b0001101, 7'b0000000}, 4'hF};
    vt[3] = '{16'h9EF0, 4'b1010, 4'h0, {7'b0000100, 7'b0110000, 7'b0111000, 7'b0000001}, 4'b0101};
`ifdef SEG_LZ_SUPPRESS_EN
    vt[4] = '{16'h0050, 4'b1000, 4'h0, {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, 4'b0111};
`else
    vt[4] = '{16'h0050, 4'b1000, 4'h0, {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 4'b0111};
`endif
    #22;
    chk_dark("reset");
    #1 rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    load = 1'b1;
    {digits_in, dp_in, blank_in} = {vt[0].dig, vt[0].dp, vt[0].blk};
    for (int i = 0; i < NV; i++) begin
      for (int t = 0; t < 32; t++) begin
        step();
        idx = t / 8;
        ea = (t % 8 < 2) ? 4'hF : ~(4'b0001 << idx);
        chk("anode", 8'(anode_n), 8'(ea));
        chk("seg", 8'(seg_n), 8'(vt[i].seg[idx]));
        chk("dp", 8'(dp_n), 8'(vt[i].dpn[idx]));
        chk("idx", 8'(scan_idx), 8'(idx));
        chk("fdone", 8'(frame_done), 8'(t == 31));
        load = t == 19 && i < NV - 1;
        if (i < NV - 1) {digits_in, dp_in, blank_in} = {vt[i+1].dig, vt[i+1].dp, vt[i+1].blk};
      end
    end
    load = 1'b1;
    {digits_in, dp_in, blank_in} = {16'h1234, 4'h0, 4'h0};
    step();
    load = 1'b0;
    chk("bload_seg", 8'(seg_n), 8'(7'b1001100));
    chk("bload_anode", 8'(anode_n), 8'hF);
    chk("bload_idx", 8'(scan_idx), 8'h0);
    repeat (4) step();
    chk("pre_dis_anode", 8'(anode_n), 8'b1110);
    enable = 1'b0;
    step();
    chk_dark("dis");
    step();
    chk_dark("dis2");
    enable = 1'b1;
    step();
    chk("en_anode0", 8'(anode_n), 8'hF);
    chk("en_idx", 8'(scan_idx), 8'h0);
    chk("en_seg", 8'(seg_n), 8'(7'b1001100));
    step();
    chk("en_anode1", 8'(anode_n), 8'hF);
    step();
    chk("en_anode2", 8'(anode_n), 8'b1110);
    repeat (8) step();
    chk("pre_rst_anode", 8'(anode_n), 8'b1101);
    chk("pre_rst_idx", 8'(scan_idx), 8'h1);
    chk("pre_rst_seg", 8'(seg_n), 8'(7'b0000110));
    #2 rst = 1'b1;
    #1 chk_dark("arst");
    #1 rst = 1'b0;
    step();
    chk("post_rst_anode", 8'(anode_n), 8'hF);
    chk("post_rst_seg", 8'(seg_n), 8'(7'b0000001));
    repeat (2) step();
    chk("post_rst_show", 8'(anode_n), 8'b1110);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
